// File: rtl/ayatsuki_dmem_if.sv
// Data-port bundle between the ayatsuki_core data side (master) and the data memory (slave).
interface ayatsuki_dmem_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_enable_i;
    logic              mem_r_enable_i;
    logic              mem_w_enable_i;
    logic [ADDR_W-1:0] mem_r_addr_i;
    logic [ADDR_W-1:0] mem_w_addr_i;
    logic [31:0]       mem_data_i;
    logic [31:0]       mem_data_o;
    logic              fault_clr_i;
    logic              fault_o;
    logic [ADDR_W-1:0] fault_addr_o;
    logic              fault_wr_o;

    modport master (
        output mem_enable_i, mem_r_enable_i, mem_w_enable_i,
        output mem_r_addr_i, mem_w_addr_i, mem_data_i, fault_clr_i,
        input  mem_data_o, fault_o, fault_addr_o, fault_wr_o
    );

    modport slave (
        input  mem_enable_i, mem_r_enable_i, mem_w_enable_i,
        input  mem_r_addr_i, mem_w_addr_i, mem_data_i, fault_clr_i,
        output mem_data_o, fault_o, fault_addr_o, fault_wr_o
    );
endinterface

// File: rtl/ayatsuki_dmem.sv
// Byte-addressed big-endian data memory: four byte banks, 1-cycle registered read,
// per-byte write-first forwarding and a sticky first-fault record for out-of-range accesses.
module ayatsuki_dmem #(
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ayatsuki_dmem_if.slave       bus
);
    localparam int unsigned ROWS  = DEPTH / 4;
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 4);

    logic              rd, wr, rd_in, wr_in, wr_en, rd_fault, wr_fault;
    logic [ADDR_W-1:0] ra, wa, diff;
    logic [3:0][7:0]   wr_lane;
    logic [3:0][7:0]   bank_rd;
    logic [3:0][7:0]   rd_lane;

    logic [31:0]       data_o_d, data_o_q;
    logic              fault_d, fault_q;
    logic [ADDR_W-1:0] fault_addr_d, fault_addr_q;
    logic              fault_wr_d, fault_wr_q;

    // Request decode; lane 0 of the write word is the lowest byte address.
    always_comb begin
        ra       = bus.mem_r_addr_i;
        wa       = bus.mem_w_addr_i;
        rd       = bus.mem_enable_i & bus.mem_r_enable_i;
        wr       = bus.mem_enable_i & bus.mem_w_enable_i;
        rd_in    = (ra <= LAST_A);
        wr_in    = (wa <= LAST_A);
        rd_fault = rd & ~rd_in;
        wr_fault = wr & ~wr_in;
        wr_en    = wr & wr_in & ~rst;
        for (int j = 0; j < 4; j++) begin
            wr_lane[j] = bus.mem_data_i[31 - 8*j -: 8];
        end
    end

    // Each bank serves the lane whose byte address falls in it; row comes from that byte address.
    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [7:0]       ram [ROWS];
        logic [1:0]       rd_off, wr_off;
        logic [ROW_W-1:0] rd_row, wr_row;

        always_comb begin
            rd_off = 2'(b) - ra[1:0];
            wr_off = 2'(b) - wa[1:0];
            rd_row = ROW_W'((ra + ADDR_W'(rd_off)) >> 2);
            wr_row = ROW_W'((wa + ADDR_W'(wr_off)) >> 2);
        end

        always_ff @(posedge clk) begin
            if (wr_en) begin
                ram[wr_row] <= wr_lane[wr_off];
            end
        end

        assign bank_rd[b] = ram[rd_row];
    end

    // Rotate banks into lane order, then override lanes hit by a same-cycle write.
    always_comb begin
        diff = '0;
        for (int k = 0; k < 4; k++) begin
            rd_lane[k] = bank_rd[2'(ra[1:0] + 2'(k))];
            diff       = ra + ADDR_W'(k) - wa;
            if (wr && wr_in && (diff < ADDR_W'(4))) begin
                rd_lane[k] = wr_lane[diff[1:0]];
            end
        end
    end

    // Next-state for read data and the fault record; a clear and a new fault in one cycle keeps the new one.
    always_comb begin
        data_o_d     = data_o_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        fault_wr_d   = fault_wr_q;

        if (rd) begin
            data_o_d = rd_in ? {rd_lane[0], rd_lane[1], rd_lane[2], rd_lane[3]} : 32'h0;
        end

        if (bus.fault_clr_i) begin
            fault_d      = 1'b0;
            fault_addr_d = '0;
            fault_wr_d   = 1'b0;
        end

        if (!fault_d && (wr_fault || rd_fault)) begin
            fault_d      = 1'b1;
            fault_addr_d = wr_fault ? wa : ra;
            fault_wr_d   = wr_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o_q     <= 32'h0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            fault_wr_q   <= 1'b0;
        end else begin
            data_o_q     <= data_o_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            fault_wr_q   <= fault_wr_d;
        end
    end

    assign bus.mem_data_o   = data_o_q;
    assign bus.fault_o      = fault_q;
    assign bus.fault_addr_o = fault_addr_q;
    assign bus.fault_wr_o   = fault_wr_q;
endmodule

// File: tb/tb_ayatsuki_dmem.sv
// Testbench for ayatsuki_dmem: directed vector table, then random traffic against a byte-array model.
module tb_ayatsuki_dmem;
    localparam int unsigned DEPTH = 2048;
    localparam logic [31:0] LAST_A = 32'(DEPTH - 4);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ayatsuki_dmem_if #(.ADDR_W(32)) bus ();

    ayatsuki_dmem #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        bit          rst, en, re, we, clr;
        logic [31:0] ra, wa, wd;
        logic [31:0] ed;
        bit          ef;
        logic [31:0] efa;
        bit          efw;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: flat byte array plus the four visible outputs.
    logic [7:0]  mem_m [DEPTH];
    logic [31:0] m_data, m_faddr;
    bit          m_f, m_fwr;

    function automatic vec_t mk(string n, bit r, bit en, bit re, bit we, bit clr,
                                logic [31:0] ra, logic [31:0] wa, logic [31:0] wd,
                                logic [31:0] ed, bit ef, logic [31:0] efa, bit efw);
        vec_t v;
        v.name = n; v.rst = r; v.en = en; v.re = re; v.we = we; v.clr = clr;
        v.ra = ra; v.wa = wa; v.wd = wd; v.ed = ed; v.ef = ef; v.efa = efa; v.efw = efw;
        return v;
    endfunction

    task automatic model_step(bit r, bit en, bit re, bit we, bit clr,
                              logic [31:0] ra, logic [31:0] wa, logic [31:0] wd);
        bit rdv, wrv, rin, win, rf, wf;
        if (r) begin
            m_data = 32'h0; m_f = 1'b0; m_faddr = 32'h0; m_fwr = 1'b0;
        end else begin
            rdv = en & re;
            wrv = en & we;
            rin = (ra <= LAST_A);
            win = (wa <= LAST_A);
            rf  = rdv & ~rin;
            wf  = wrv & ~win;
            // Write first, then read the updated array: this is write-first forwarding.
            if (wrv && win)
                for (int j = 0; j < 4; j++) mem_m[wa + 32'(j)] = wd[31 - 8*j -: 8];
            if (rdv)
                m_data = rin ? {mem_m[ra], mem_m[ra + 32'd1], mem_m[ra + 32'd2], mem_m[ra + 32'd3]}
                             : 32'h0;
            if (clr) begin
                m_f = 1'b0; m_faddr = 32'h0; m_fwr = 1'b0;
            end
            if (!m_f && (rf || wf)) begin
                m_f = 1'b1; m_faddr = wf ? wa : ra; m_fwr = wf;
            end
        end
    endtask

    task automatic drive_cycle(bit r, bit en, bit re, bit we, bit clr,
                               logic [31:0] ra, logic [31:0] wa, logic [31:0] wd);
        rst                = r;
        bus.mem_enable_i   = en;
        bus.mem_r_enable_i = re;
        bus.mem_w_enable_i = we;
        bus.fault_clr_i    = clr;
        bus.mem_r_addr_i   = ra;
        bus.mem_w_addr_i   = wa;
        bus.mem_data_i     = wd;
        model_step(r, en, re, we, clr, ra, wa, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] ed, bit ef, logic [31:0] efa, bit efw);
        checks++;
        if (bus.mem_data_o !== ed || bus.fault_o !== ef ||
            bus.fault_addr_o !== efa || bus.fault_wr_o !== efw) begin
            failures++;
            $display("FAIL %s: got data=%h fault=%b faddr=%h fwr=%b, want data=%h fault=%b faddr=%h fwr=%b",
                     name, bus.mem_data_o, bus.fault_o, bus.fault_addr_o, bus.fault_wr_o,
                     ed, ef, efa, efw);
        end
    endtask

    vec_t vecs[29];

    initial begin
        logic [31:0] ra, wa;
        bit r, re, we, clr;

        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h0;
        m_data = 32'h0; m_f = 1'b0; m_faddr = 32'h0; m_fwr = 1'b0;

        rst = 1'b1;
        bus.mem_enable_i = 1'b0; bus.mem_r_enable_i = 1'b0; bus.mem_w_enable_i = 1'b0;
        bus.fault_clr_i = 1'b0; bus.mem_r_addr_i = '0; bus.mem_w_addr_i = '0; bus.mem_data_i = '0;

        //                name          rst en re we clr  ra           wa           wd           exp_data     ef  efa          efw
        vecs[0]  = mk("rst_wr0",        1, 1, 0, 1, 0, 32'h0,       32'h0,       32'hDEADBEEF, 32'h0,       0, 32'h0,       0);
        vecs[1]  = mk("rst_wr1",        1, 1, 0, 1, 0, 32'h0,       32'h0,       32'hDEADBEEF, 32'h0,       0, 32'h0,       0);
        vecs[2]  = mk("rd0_after_rst",  0, 1, 1, 0, 0, 32'h0,       32'h0,       32'h0,        32'h0,       0, 32'h0,       0);
        vecs[3]  = mk("wr10",           0, 1, 0, 1, 0, 32'h0,       32'h10,      32'h11223344, 32'h0,       0, 32'h0,       0);
        vecs[4]  = mk("rd10",           0, 1, 1, 0, 0, 32'h10,      32'h0,       32'h0,        32'h11223344,0, 32'h0,       0);
        vecs[5]  = mk("rd11",           0, 1, 1, 0, 0, 32'h11,      32'h0,       32'h0,        32'h22334400,0, 32'h0,       0);
        vecs[6]  = mk("wr21",           0, 1, 0, 1, 0, 32'h0,       32'h21,      32'hAABBCCDD, 32'h22334400,0, 32'h0,       0);
        vecs[7]  = mk("rd20",           0, 1, 1, 0, 0, 32'h20,      32'h0,       32'h0,        32'h00AABBCC,0, 32'h0,       0);
        vecs[8]  = mk("rd24",           0, 1, 1, 0, 0, 32'h24,      32'h0,       32'h0,        32'hDD000000,0, 32'h0,       0);
        vecs[9]  = mk("wr44",           0, 1, 0, 1, 0, 32'h0,       32'h44,      32'h12340000, 32'hDD000000,0, 32'h0,       0);
        vecs[10] = mk("fwd_wr40_rd42",  0, 1, 1, 1, 0, 32'h42,      32'h40,      32'hCAFEF00D, 32'hF00D1234,0, 32'h0,       0);
        vecs[11] = mk("rd_oor_7fd",     0, 1, 1, 0, 0, 32'h7FD,     32'h0,       32'h0,        32'h0,       1, 32'h7FD,     0);
        vecs[12] = mk("wr_oor_sticky",  0, 1, 0, 1, 0, 32'h0,       32'hFFFFFFF0,32'h55555555, 32'h0,       1, 32'h7FD,     0);
        vecs[13] = mk("clr_and_wr800",  0, 1, 0, 1, 1, 32'h0,       32'h800,     32'h66666666, 32'h0,       1, 32'h800,     1);
        vecs[14] = mk("wr_last_7fc",    0, 1, 0, 1, 0, 32'h0,       32'h7FC,     32'h0A0B0C0D, 32'h0,       1, 32'h800,     1);
        vecs[15] = mk("rd_last_7fc",    0, 1, 1, 0, 0, 32'h7FC,     32'h0,       32'h0,        32'h0A0B0C0D,1, 32'h800,     1);
        vecs[16] = mk("clr_only",       0, 0, 0, 0, 1, 32'h0,       32'h0,       32'h0,        32'h0A0B0C0D,0, 32'h0,       0);
        vecs[17] = mk("rd10_again",     0, 1, 1, 0, 0, 32'h10,      32'h0,       32'h0,        32'h11223344,0, 32'h0,       0);
        vecs[18] = mk("hold1",          0, 0, 0, 0, 0, 32'h0,       32'h0,       32'h0,        32'h11223344,0, 32'h0,       0);
        vecs[19] = mk("hold2",          0, 1, 0, 0, 0, 32'h7FD,     32'h0,       32'h0,        32'h11223344,0, 32'h0,       0);
        vecs[20] = mk("hold3",          0, 0, 1, 0, 0, 32'h7FD,     32'h0,       32'h0,        32'h11223344,0, 32'h0,       0);
        vecs[21] = mk("rst_mid",        1, 0, 0, 0, 0, 32'h0,       32'h0,       32'h0,        32'h0,       0, 32'h0,       0);
        vecs[22] = mk("rd10_post_rst",  0, 1, 1, 0, 0, 32'h10,      32'h0,       32'h0,        32'h11223344,0, 32'h0,       0);
        vecs[23] = mk("both_oor",       0, 1, 1, 1, 0, 32'h900,     32'h1000,    32'h0,        32'h0,       1, 32'h1000,    1);
        vecs[24] = mk("clr2",           0, 0, 0, 0, 1, 32'h0,       32'h0,       32'h0,        32'h0,       0, 32'h0,       0);
        vecs[25] = mk("fwd_partial",    0, 1, 1, 1, 0, 32'h50,      32'h51,      32'h01020304, 32'h00010203,0, 32'h0,       0);
        vecs[26] = mk("rd54",           0, 1, 1, 0, 0, 32'h54,      32'h0,       32'h0,        32'h04000000,0, 32'h0,       0);
        vecs[27] = mk("gated_en",       0, 0, 1, 1, 0, 32'h10,      32'h10,      32'hFFFFFFFF, 32'h04000000,0, 32'h0,       0);
        vecs[28] = mk("rd10_not_wr",    0, 1, 1, 0, 0, 32'h10,      32'h0,       32'h0,        32'h11223344,0, 32'h0,       0);

        for (int i = 0; i < 29; i++) begin
            drive_cycle(vecs[i].rst, vecs[i].en, vecs[i].re, vecs[i].we, vecs[i].clr,
                        vecs[i].ra, vecs[i].wa, vecs[i].wd);
            check(vecs[i].name, vecs[i].ed, vecs[i].ef, vecs[i].efa, vecs[i].efw);
        end

        // Random traffic concentrated on a small window and the top-of-memory boundary.
        for (int n = 0; n < 800; n++) begin
            for (int s = 0; s < 2; s++) begin
                logic [31:0] a;
                case ($urandom_range(0, 7))
                    0, 1, 2, 3, 4: a = 32'($urandom_range(0, 63));
                    5:             a = 32'($urandom_range(32'h7F0, 32'h808));
                    6:             a = $urandom;
                    default:       a = 32'($urandom_range(0, DEPTH - 1));
                endcase
                if (s == 0) ra = a; else wa = a;
            end
            r   = ($urandom_range(0, 59) == 0);
            re  = $urandom_range(0, 1) == 1;
            we  = $urandom_range(0, 1) == 1;
            clr = ($urandom_range(0, 15) == 0);
            drive_cycle(r, ($urandom_range(0, 7) != 0), re, we, clr, ra, wa, $urandom);
            check($sformatf("rand[%0d]", n), m_data, m_f, m_faddr, m_fwr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
